// File: rtl/acq_buffer_sequencer_if.sv
// Handshake bundle between the A-line sequencer, the addressing counter,
// the dual-bank sample buffer and its reader.
interface acq_buffer_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             sweep_trig;
    logic [10:0]      sample_position;
    logic             acq_done;
    logic             counter_sclr;
    logic             dualMSB_write;
    logic             dualMSB_read;
    logic             buf_ready;
    logic             buf_ack;
    logic             overrun;
    logic [CNT_W-1:0] aline_count;

    // Environment side: drives control, trigger, counter status and reader ack.
    modport master (
        output enable, sweep_trig, sample_position, acq_done, buf_ack,
        input  counter_sclr, dualMSB_write, dualMSB_read, buf_ready, overrun, aline_count
    );

    // Sequencer side.
    modport slave (
        input  enable, sweep_trig, sample_position, acq_done, buf_ack,
        output counter_sclr, dualMSB_write, dualMSB_read, buf_ready, overrun, aline_count
    );
endinterface

// File: rtl/acq_buffer_sequencer.sv
// A-line acquisition sequencer: arms on enable, acquires one A-line per sweep
// trigger, then hands the filled bank to the reader by swapping buffer banks.
module acq_buffer_sequencer #(
    parameter int NSAMPLES = 1170,
    parameter int CNT_W    = 16
) (
    input  logic                    clock,
    input  logic                    areset,
    acq_buffer_sequencer_if.slave   bus
);
    if (NSAMPLES < 1 || NSAMPLES > 2046) begin : g_bad_nsamples
        $error("NSAMPLES out of range 1..2046");
    end

    typedef enum logic [1:0] {IDLE, ARM, ACQ, SWAP} state_t;

    state_t           state, state_nx;
    logic             trig_d;
    logic             seen_busy, seen_busy_nx;
    logic             sclr, sclr_nx;
    logic             bank_wr, bank_wr_nx;
    logic             bank_rd;
    logic             ready, ready_nx;
    logic             ovr, ovr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             trig_rise;
    logic             ready_eff;

    assign trig_rise = bus.sweep_trig & ~trig_d;
    // A same-cycle ack frees the bank before any swap decision is made.
    assign ready_eff = ready & ~bus.buf_ack;

    always_comb begin
        state_nx     = state;
        seen_busy_nx = seen_busy;
        bank_wr_nx   = bank_wr;
        ready_nx     = ready_eff;
        ovr_nx       = ovr;
        cnt_nx       = cnt;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_nx = ARM;
                    ovr_nx   = 1'b0;
                end
            end
            ARM: begin
                if (!bus.enable) begin
                    state_nx = IDLE;
                end else if (trig_rise) begin
                    state_nx     = ACQ;
                    seen_busy_nx = 1'b0;
                end
            end
            ACQ: begin
                // Only a busy->done transition of the counter ends the A-line.
                if (bus.acq_done && seen_busy) begin
                    state_nx = SWAP;
                end else if (!bus.acq_done) begin
                    seen_busy_nx = 1'b1;
                end
            end
            SWAP: begin
                if (!ready_eff) begin
                    bank_wr_nx = ~bank_wr;
                    ready_nx   = 1'b1;
                    cnt_nx     = cnt + CNT_W'(1);
                end else begin
                    ovr_nx = 1'b1;
                end
                state_nx = bus.enable ? ARM : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        sclr_nx = (state_nx != ACQ);
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            trig_d    <= 1'b0;
            seen_busy <= 1'b0;
            sclr      <= 1'b1;
            bank_wr   <= 1'b0;
            bank_rd   <= 1'b1;
            ready     <= 1'b0;
            ovr       <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            trig_d    <= bus.sweep_trig;
            seen_busy <= seen_busy_nx;
            sclr      <= sclr_nx;
            bank_wr   <= bank_wr_nx;
            bank_rd   <= ~bank_wr_nx;
            ready     <= ready_nx;
            ovr       <= ovr_nx;
            cnt       <= cnt_nx;
        end
    end

    assign bus.counter_sclr  = sclr;
    assign bus.dualMSB_write = bank_wr;
    assign bus.dualMSB_read  = bank_rd;
    assign bus.buf_ready     = ready;
    assign bus.overrun       = ovr;
    assign bus.aline_count   = cnt;
endmodule

// File: doc/acq_buffer_sequencer.md
ACQ_BUFFER_SEQUENCER -- requirements
Module: acq_buffer_sequencer

Interface
REQ-001 Parameter NSAMPLES, default 1170, samples per A-line; SHALL satisfy 1 <= NSAMPLES <= 2046.
REQ-002 Parameter CNT_W, default 16, width of aline_count.
REQ-003 clock  in  1  single clock for all logic.
REQ-004 areset  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 enable  in  1  level; 1 = run continuous A-line acquisition.
REQ-006 sweep_trig  in  1  laser sweep trigger, already synchronous to clock; rising edge starts an A-line.
REQ-007 sample_position  in  11  sample address from the addressing counter; 2047 = out of window.
REQ-008 acq_done  in  1  counter not-busy flag; 1 when sample_position is outside 0..NSAMPLES-1.
REQ-009 counter_sclr  out  1  synchronous clear to the addressing counter.
REQ-010 dualMSB_write  out  1  bank select, MSB of write address to the dual sample buffer.
REQ-011 dualMSB_read  out  1  bank select, MSB of read address; always the complement of dualMSB_write.
REQ-012 buf_ready  out  1  level; 1 = bank dualMSB_read holds a complete, unconsumed A-line.
REQ-013 buf_ack  in  1  one-cycle pulse from reader: bank consumed.
REQ-014 overrun  out  1  sticky; an A-line was dropped because the reader had not acked.
REQ-015 aline_count  out  CNT_W  number of A-lines handed to the reader; wraps modulo 2^CNT_W.

Function
REQ-016 SHALL be a registered FSM with states IDLE, ARM, ACQ, SWAP; all outputs registered.
REQ-017 Trigger edge: trig_rise = sweep_trig & ~sweep_trig_d, with sweep_trig_d a one-cycle delay register.
REQ-018 IDLE: counter_sclr=1; enable=1 -> ARM; on this IDLE->ARM transition overrun SHALL clear to 0.
REQ-019 ARM: counter_sclr=1; enable=0 -> IDLE; trig_rise=1 -> ACQ, counter_sclr=0 from the next edge (one-cycle latency trigger to counter release).
REQ-020 ACQ: counter_sclr=0; seen_busy flag sets when acq_done=0; acq_done=1 with seen_busy=1 -> SWAP; seen_busy clears on ACQ entry.
REQ-021 ACQ: trig_rise and enable changes SHALL be ignored; the current A-line always completes.
REQ-022 SWAP (exactly one cycle): counter_sclr=1; if buf_ready=0 after ack handling, toggle dualMSB_write (and dualMSB_read), set buf_ready=1, aline_count+1.
REQ-023 SWAP with buf_ready=1 and no buf_ack same cycle: no bank toggle, buf_ready stays 1, aline_count unchanged, overrun<=1.
REQ-024 SWAP exit: enable=1 -> ARM, else -> IDLE.
REQ-025 buf_ack=1 while buf_ready=1 SHALL clear buf_ready on the next edge; buf_ack while buf_ready=0 SHALL be ignored.
REQ-026 buf_ack and SWAP in the same cycle: ack processed first, swap proceeds normally (buf_ready stays 1, banks toggle, no overrun).
REQ-027 Bank toggle and buf_ready assertion SHALL occur on the same edge; reader never sees buf_ready=1 with a stale dualMSB_read.
REQ-028 A-line length SHALL be determined solely by acq_done; no internal sample counter.

Reset
REQ-029 areset=1 SHALL force immediately: state IDLE, counter_sclr=1, dualMSB_write=0, dualMSB_read=1, buf_ready=0, overrun=0, aline_count=0, sweep_trig_d=0, seen_busy=0.
REQ-030 areset asserted mid-ACQ SHALL abandon the A-line with no bank toggle; after release, operation restarts from IDLE.

Verification
REQ-031 Reset, enable=1, one trig pulse, counter model NSAMPLES=1170 -> counter_sclr low 1 cycle after trig edge; after acq_done rises, dualMSB_write=1, dualMSB_read=0, buf_ready=1, aline_count=1.
REQ-032 Three triggers, buf_ack after each buf_ready -> banks alternate 1,0,1; aline_count=3; overrun=0.
REQ-033 Two A-lines, no ack -> second SWAP: dualMSB_write stays 1, overrun=1, aline_count=1; enable 0->1 via IDLE clears overrun.
REQ-034 buf_ack in SWAP cycle of second A-line -> no overrun, dualMSB_write=0, buf_ready=1, aline_count=2.
REQ-035 Extra trig mid-ACQ and enable=0 mid-ACQ -> A-line completes once, aline_count+1, FSM to IDLE, counter_sclr=1.
REQ-036 areset pulse mid-ACQ (sample_position=500) -> all outputs at reset values asynchronously, no bank toggle.
